// File: rtl/button_event_fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : button_pkg
//  Brief    : Event encoding constants and payload helper for button_event_fifo.
//  Revision : 1.0
// ============================================================================
package button_pkg;

    localparam int EVT_VALID_BIT = 7;
    localparam int EVT_OVF_BIT   = 6;
    localparam int EVT_KIND_BIT  = 5;
    localparam int EVT_CH_MSB    = 4;
    localparam int PAYLOAD_W     = EVT_KIND_BIT + 1;

    typedef enum logic {
        KIND_PRESS   = 1'b0,
        KIND_RELEASE = 1'b1
    } evt_kind_e;

    // FIFO stores only {kind, channel}; valid and overflow are added at the read port.
    function automatic logic [PAYLOAD_W-1:0] evt_payload(input evt_kind_e kind,
                                                         input logic [EVT_CH_MSB:0] ch);
        return {kind, ch};
    endfunction

endpackage
`default_nettype wire

// File: rtl/button_event_fifo_if.sv
`default_nettype none
// ============================================================================
//  Module   : button_event_fifo_if
//  Brief    : Button inputs and CPU-side event port of button_event_fifo.
//  Revision : 1.0
// ============================================================================
interface button_event_fifo_if #(
    parameter int N_BTN = 2
);
    logic [N_BTN-1:0] btn;
    logic             button_read;
    logic [7:0]       button_op;
    logic             empty;
    logic             full;
    logic             overflow;

    modport master (
        output btn, button_read,
        input  button_op, empty, full, overflow
    );

    modport slave (
        input  btn, button_read,
        output button_op, empty, full, overflow
    );
endinterface
`default_nettype wire

// File: rtl/button_event_fifo_debounce.sv
`default_nettype none
// ============================================================================
//  Module   : button_debounce
//  Brief    : Two-flop synchroniser and counter debouncer with edge pulses.
//  Revision : 1.0
// ============================================================================
module button_debounce #(
    parameter int DEBOUNCE = 4
) (
    input  wire logic clk,
    input  wire logic reset,
    input  wire logic btn_i,
    output logic      stable_o,
    output logic      rise_o,
    output logic      fall_o
);
    localparam int CNT_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);

    logic             s1_q, s2_q;
    logic             stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             w_accept;

    assign w_accept = (s2_q != stable_q) && (cnt_q == CNT_LAST);

    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (s2_q == stable_q) begin
            cnt_d = '0;
        end else if (w_accept) begin
            stable_d = s2_q;
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            s1_q     <= btn_i;
            s2_q     <= s1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    // Pulses coincide with the edge at which stable changes.
    assign stable_o = stable_q;
    assign rise_o   = w_accept & s2_q;
    assign fall_o   = w_accept & ~s2_q;

endmodule
`default_nettype wire

// File: rtl/button_event_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : button_event_fifo
//  Brief    : N-button debouncer with priority arbiter and event FIFO.
//             Define RELEASE_EVT_EN to also queue release events.
//  Revision : 1.0
// ============================================================================
module button_event_fifo
    import button_pkg::*;
#(
    parameter int N_BTN    = 2,
    parameter int DEPTH    = 4,
    parameter int DEBOUNCE = 4
) (
    input  wire logic          clk,
    input  wire logic          reset,
    button_event_fifo_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
`ifdef RELEASE_EVT_EN
    localparam int NREQ = 2 * N_BTN;
`else
    localparam int NREQ = N_BTN;
`endif

    logic [N_BTN-1:0]     w_rise, w_fall, w_stable;
    logic [NREQ-1:0]      w_set, w_gnt, pend_q, pend_d;
    logic [PAYLOAD_W-1:0] w_req_pl [NREQ];
    logic [PAYLOAD_W-1:0] w_push_pl;
    logic                 w_unused_levels;

    // Request slot order is the priority order: channel first, press before release.
    for (genvar ch = 0; ch < N_BTN; ch++) begin : g_ch
        button_debounce #(.DEBOUNCE(DEBOUNCE)) u_deb (
            .clk      (clk),
            .reset    (reset),
            .btn_i    (bus.btn[ch]),
            .stable_o (w_stable[ch]),
            .rise_o   (w_rise[ch]),
            .fall_o   (w_fall[ch])
        );
`ifdef RELEASE_EVT_EN
        assign w_set[2*ch]      = w_rise[ch];
        assign w_set[2*ch+1]    = w_fall[ch];
        assign w_req_pl[2*ch]   = evt_payload(KIND_PRESS,   5'(ch));
        assign w_req_pl[2*ch+1] = evt_payload(KIND_RELEASE, 5'(ch));
`else
        assign w_set[ch]    = w_rise[ch];
        assign w_req_pl[ch] = evt_payload(KIND_PRESS, 5'(ch));
`endif
    end

`ifdef RELEASE_EVT_EN
    assign w_unused_levels = ^w_stable;
`else
    assign w_unused_levels = ^{w_stable, w_fall};
`endif

    // Lowest set bit wins.
    assign w_gnt  = pend_q & (~pend_q + NREQ'(1));
    assign pend_d = (pend_q & ~w_gnt) | w_set;

    always_comb begin
        w_push_pl = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_gnt[i]) w_push_pl = w_req_pl[i];
        end
    end

    logic [PAYLOAD_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 ovf_q, ovf_d;
    logic                 w_empty, w_full, w_gnt_vld, w_pop, w_push, w_drop;

    assign w_empty   = (count_q == '0);
    assign w_full    = (count_q == FULL_CNT);
    assign w_gnt_vld = |pend_q;
    assign w_pop     = bus.button_read & ~w_empty;
    assign w_push    = w_gnt_vld & (~w_full | w_pop);
    assign w_drop    = w_gnt_vld & w_full & ~w_pop;

    always_comb begin
        wr_ptr_d = w_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = w_pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        ovf_d = w_pop ? 1'b0 : (ovf_q | w_drop);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            pend_q   <= pend_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage is never read while empty, so it needs no reset.
    always_ff @(posedge clk) begin
        if (w_push) mem_q[wr_ptr_q] <= w_push_pl;
    end

    logic [7:0] w_op;
    always_comb begin
        w_op = '0;
        if (!w_empty) begin
            w_op[EVT_VALID_BIT]    = 1'b1;
            w_op[EVT_OVF_BIT]      = ovf_q;
            w_op[EVT_KIND_BIT:0]   = mem_q[rd_ptr_q];
        end
    end

    assign bus.button_op = w_op;
    assign bus.empty     = w_empty;
    assign bus.full      = w_full;
    assign bus.overflow  = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_button_event_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_button_event_fifo
//  Brief    : Self-checking bench for button_event_fifo (N_BTN=2, DEPTH=4, DEBOUNCE=4).
//  Revision : 1.0
// ============================================================================
module tb_button_event_fifo;
    localparam int N_BTN    = 2;
    localparam int DEPTH    = 4;
    localparam int DEBOUNCE = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    button_event_fifo_if #(.N_BTN(N_BTN)) bus ();

    button_event_fifo #(
        .N_BTN    (N_BTN),
        .DEPTH    (DEPTH),
        .DEBOUNCE (DEBOUNCE)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int         n_checks  = 0;
    int         n_fail    = 0;
    logic [7:0] exp_q[$];
    logic       ovf_model = 1'b0;

    typedef struct {
        logic [N_BTN-1:0] mask;
        int               hold;
        int               n_exp;
        logic [7:0]       exp0;
        logic [7:0]       exp1;
    } vec_t;
    vec_t vecs[6];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Reference queue with the same drop-when-full rule as the hardware.
    task automatic add_evt(input logic [7:0] e);
        if (exp_q.size() < DEPTH) exp_q.push_back(e);
        else ovf_model = 1'b1;
    endtask

    task automatic read_pulse();
        bus.button_read = 1'b1;
        tick(1);
        bus.button_read = 1'b0;
    endtask

    task automatic drain(input string tag);
        logic [7:0] e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (ovf_model) e[6] = 1'b1;
            check({tag, " empty"}, 8'(bus.empty), 8'h00);
            check({tag, " op"}, bus.button_op, e);
            read_pulse();
            ovf_model = 1'b0;
        end
        check({tag, " end empty"}, 8'(bus.empty), 8'h01);
        check({tag, " end op"}, bus.button_op, 8'h00);
        check({tag, " end ovf"}, 8'(bus.overflow), 8'(ovf_model));
    endtask

    task automatic press_release(input int ch);
        bus.btn = N_BTN'(1 << ch);
        tick(6);
        bus.btn = '0;
        tick(14);
        add_evt(8'(8'h80 | ch));
`ifdef RELEASE_EVT_EN
        add_evt(8'(8'hA0 | ch));
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got 0 expected 1");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{mask: 2'b10, hold: 8, n_exp: 1, exp0: 8'h81, exp1: 8'h00};
        vecs[1] = '{mask: 2'b01, hold: 3, n_exp: 0, exp0: 8'h00, exp1: 8'h00};
        vecs[2] = '{mask: 2'b01, hold: 4, n_exp: 1, exp0: 8'h80, exp1: 8'h00};
        vecs[3] = '{mask: 2'b11, hold: 6, n_exp: 2, exp0: 8'h80, exp1: 8'h81};
        vecs[4] = '{mask: 2'b01, hold: 2, n_exp: 0, exp0: 8'h00, exp1: 8'h00};
        vecs[5] = '{mask: 2'b10, hold: 5, n_exp: 1, exp0: 8'h81, exp1: 8'h00};

        bus.btn         = '0;
        bus.button_read = 1'b0;
        reset           = 1'b1;
        tick(2);
        check("rst empty", 8'(bus.empty), 8'h01);
        check("rst full", 8'(bus.full), 8'h00);
        check("rst ovf", 8'(bus.overflow), 8'h00);
        check("rst op", bus.button_op, 8'h00);
        reset = 1'b0;

        // Press latency: first sampled at edge 1, queued at edge 7.
        bus.btn = 2'b10;
        tick(6);
        check("lat empty@6", 8'(bus.empty), 8'h01);
        tick(1);
        check("lat empty@7", 8'(bus.empty), 8'h00);
        check("lat op@7", bus.button_op, 8'h81);
        read_pulse();
        check("lat pop empty", 8'(bus.empty), 8'h01);
        check("lat pop op", bus.button_op, 8'h00);
        bus.btn = '0;
        tick(14);
`ifdef RELEASE_EVT_EN
        add_evt(8'hA1);
`endif
        drain("lat");

        for (int i = 0; i < 6; i++) begin
            bus.btn = vecs[i].mask;
            tick(vecs[i].hold);
            bus.btn = '0;
            if (vecs[i].n_exp > 0) add_evt(vecs[i].exp0);
            if (vecs[i].n_exp > 1) add_evt(vecs[i].exp1);
`ifdef RELEASE_EVT_EN
            if (vecs[i].n_exp > 0) add_evt(vecs[i].exp0 | 8'h20);
            if (vecs[i].n_exp > 1) add_evt(vecs[i].exp1 | 8'h20);
`endif
            tick(20);
            check($sformatf("vec%0d ovf", i), 8'(bus.overflow), 8'h00);
            drain($sformatf("vec%0d", i));
        end

        for (int k = 0; k < 6; k++) press_release(k % 2);
        check("ovf full", 8'(bus.full), 8'h01);
        check("ovf flag", 8'(bus.overflow), 8'h01);
        drain("ovf");

        // Full FIFO: new grant lands on the same edge as a pop.
        for (int k = 0; exp_q.size() < DEPTH; k++) press_release(k % 2);
        check("pp full before", 8'(bus.full), 8'h01);
        bus.btn = 2'b01;
        tick(6);
        check("pp head", bus.button_op, exp_q[0]);
        bus.button_read = 1'b1;
        tick(1);
        bus.button_read = 1'b0;
        exp_q.delete(0);
        add_evt(8'h80);
        check("pp full after", 8'(bus.full), 8'h01);
        check("pp ovf", 8'(bus.overflow), 8'h00);
        drain("pp");
        bus.btn = '0;
        tick(14);
`ifdef RELEASE_EVT_EN
        add_evt(8'hA0);
`endif
        drain("pp rel");

        // Asynchronous reset flushes queue and overflow.
        for (int k = 0; !ovf_model && k < 8; k++) press_release(k % 2);
        check("mid ovf set", 8'(bus.overflow), 8'h01);
        reset = 1'b1;
        #1;
        check("async empty", 8'(bus.empty), 8'h01);
        check("async ovf", 8'(bus.overflow), 8'h00);
        tick(1);
        reset = 1'b0;
        exp_q.delete();
        ovf_model = 1'b0;
        check("mid full", 8'(bus.full), 8'h00);
        check("mid op", bus.button_op, 8'h00);

        // Button held through reset yields one fresh press.
        bus.btn = 2'b10;
        tick(10);
        check("held pre empty", 8'(bus.empty), 8'h00);
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(6);
        check("held empty@6", 8'(bus.empty), 8'h01);
        tick(1);
        check("held op@7", bus.button_op, 8'h81);
        add_evt(8'h81);
        bus.btn = '0;
        tick(14);
`ifdef RELEASE_EVT_EN
        add_evt(8'hA1);
`endif
        drain("held");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
